// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard with multi-port operand forwarding and stall generation
module hazard_scoreboard #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NFWD = 2,
    parameter int MAX_LAT = 4,
    localparam int CW = $clog2(MAX_LAT),
    localparam int NREG = 2 ** AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      rs_addr,
    input  logic [AW-1:0]      rt_addr,
    input  logic               uses_rs,
    input  logic               uses_rt,
    input  logic [DW-1:0]      rs_data_in,
    input  logic [DW-1:0]      rt_data_in,
    input  logic               issue,
    input  logic               flush,
    input  logic               dst_we,
    input  logic [AW-1:0]      dst_addr,
    input  logic [CW:0]        dst_lat,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD*AW-1:0] fwd_addr,
    input  logic [NFWD*DW-1:0] fwd_data,
    output logic [DW-1:0]      rs_data,
    output logic [DW-1:0]      rt_data,
    output logic               stall,
    output logic [31:0]        stall_count
);
    logic [CW-1:0] cnt [NREG];
    logic [CW:0]   leff;
    logic [CW-1:0] lm1;
    logic          raw_rs, raw_rt, waw, accept;

    assign leff = (dst_lat == '0) ? (CW+1)'(1) : (dst_lat > (CW+1)'(MAX_LAT)) ? (CW+1)'(MAX_LAT) : dst_lat;
    assign lm1 = CW'(leff - 1'b1);
    assign raw_rs = uses_rs && rs_addr != '0 && cnt[rs_addr] != '0;
    assign raw_rt = uses_rt && rt_addr != '0 && cnt[rt_addr] != '0;
    assign waw = dst_we && dst_addr != '0 && cnt[dst_addr] > lm1;
    assign stall = issue && !flush && !rst && (raw_rs || raw_rt || waw);
    assign accept = issue && !flush && !stall;

    // Walk ports oldest to youngest so the lowest-index match is applied last and wins.
    always_comb begin
        rs_data = rs_data_in;
        rt_data = rt_data_in;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_addr[i*AW +: AW] == rs_addr) rs_data = fwd_data[i*DW +: DW];
            if (fwd_we[i] && fwd_addr[i*AW +: AW] == rt_addr) rt_data = fwd_data[i*DW +: DW];
        end
        if (rs_addr == '0) rs_data = '0;
        if (rt_addr == '0) rt_data = '0;
    end

    // Entry 0 is never loaded, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            stall_count <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= (cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
            if (accept && dst_we && dst_addr != '0) cnt[dst_addr] <= lm1;
            if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenario bench for hazard_scoreboard
module tb_hazard_scoreboard;
    logic        clk = 0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, dst_addr;
    logic        uses_rs, uses_rt, issue, flush, dst_we;
    logic [31:0] rs_data_in, rt_data_in, rs_data, rt_data, stall_count;
    logic [2:0]  dst_lat;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        stall;
    int total = 0;
    int bad = 0;
    int n;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .uses_rs(uses_rs), .uses_rt(uses_rt), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
        .issue(issue), .flush(flush), .dst_we(dst_we), .dst_addr(dst_addr), .dst_lat(dst_lat),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        rst = 0; issue = 0; flush = 0; dst_we = 0; dst_addr = 0; dst_lat = 1;
        uses_rs = 0; uses_rt = 0; rs_addr = 0; rt_addr = 0;
        rs_data_in = 32'h1111; rt_data_in = 32'h2222;
        fwd_we = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    task automatic issue_dst(input logic [4:0] a, input logic [2:0] lat);
        clr();
        issue = 1; dst_we = 1; dst_addr = a; dst_lat = lat;
    endtask

    // Counts stall cycles of the currently driven instruction (bounded), then lets it issue.
    task automatic wait_accept(output int cycles);
        #1;
        cycles = 0;
        while (stall && cycles < 8) begin
            cycles++;
            tick();
        end
        tick();
    endtask

    task automatic test_reset;
        clr();
        rst = 1; issue = 1; uses_rs = 1; rs_addr = 3;
        tick();
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
        tick();
        clr();
    endtask

    task automatic test_alu_chain;
        issue_dst(3, 1);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_producer_stall got=%b want=0", stall); end
        tick();
        issue_dst(4, 1);
        uses_rs = 1; uses_rt = 1; rs_addr = 3; rt_addr = 3;
        fwd_we = 2'b01; fwd_addr = {5'd0, 5'd3}; fwd_data = {32'h0, 32'h55};
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", stall); end
        total++; if (rs_data !== 32'h55) begin bad++; $display("FAIL alu_rs got=%h want=55", rs_data); end
        total++; if (rt_data !== 32'h55) begin bad++; $display("FAIL alu_rt got=%h want=55", rt_data); end
        tick();
    endtask

    task automatic test_load_use;
        issue_dst(5, 2);
        tick();
        issue_dst(6, 1);
        uses_rs = 1; rs_addr = 5;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall got=%b want=1", stall); end
        tick();
        fwd_we = 2'b10; fwd_addr = {5'd5, 5'd0}; fwd_data = {32'hDEAD, 32'h0};
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_release got=%b want=0", stall); end
        total++; if (rs_data !== 32'hDEAD) begin bad++; $display("FAIL load_fwd got=%h want=dead", rs_data); end
        total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL load_count got=%0d want=1", stall_count); end
        tick();
    endtask

    task automatic test_multi_cycle;
        issue_dst(7, 4);
        tick();
        clr(); issue = 1; uses_rs = 1; rs_addr = 7;
        wait_accept(n);
        total++; if (n !== 3) begin bad++; $display("FAIL lat4_stalls got=%0d want=3", n); end
        issue_dst(7, 5);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lat5_issue got=%b want=0", stall); end
        tick();
        clr(); issue = 1; uses_rs = 1; rs_addr = 7;
        wait_accept(n);
        total++; if (n !== 3) begin bad++; $display("FAIL lat5_clamp got=%0d want=3", n); end
        total++; if (stall_count !== 32'd7) begin bad++; $display("FAIL multi_count got=%0d want=7", stall_count); end
        issue_dst(10, 0);
        tick();
        clr(); issue = 1; uses_rs = 1; rs_addr = 10;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lat0_clamp got=%b want=0", stall); end
        tick();
    endtask

    task automatic test_waw;
        issue_dst(8, 4);
        tick();
        issue_dst(8, 1);
        wait_accept(n);
        total++; if (n !== 3) begin bad++; $display("FAIL waw_stalls got=%0d want=3", n); end
        issue_dst(8, 4);
        tick();
        issue_dst(8, 4);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_equal got=%b want=0", stall); end
        tick();
    endtask

    task automatic test_priority_zero;
        clr();
        issue = 1; uses_rs = 1; rs_addr = 9; rt_addr = 11; rt_data_in = 32'hABC;
        fwd_we = 2'b11; fwd_addr = {5'd9, 5'd9}; fwd_data = {32'h2, 32'h1};
        #1;
        total++; if (rs_data !== 32'h1) begin bad++; $display("FAIL prio_rs got=%h want=1", rs_data); end
        total++; if (rt_data !== 32'hABC) begin bad++; $display("FAIL nomatch_rt got=%h want=abc", rt_data); end
        rs_addr = 0; rs_data_in = 32'h77; fwd_we = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFF};
        #1;
        total++; if (rs_data !== 32'h0) begin bad++; $display("FAIL zero_rs got=%h want=0", rs_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b want=0", stall); end
        tick();
    endtask

    task automatic test_flush_reset;
        clr();
        #1;
        total++; if (stall_count !== 32'd10) begin bad++; $display("FAIL pre_flush_count got=%0d want=10", stall_count); end
        issue_dst(5, 2);
        flush = 1;
        tick();
        clr(); issue = 1; uses_rs = 1; rs_addr = 5;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flushed_lw got=%b want=0", stall); end
        tick();
        issue_dst(12, 4);
        tick();
        clr(); issue = 1; rt_addr = 12;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL unused_rt got=%b want=0", stall); end
        tick();
        uses_rt = 1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL pending_rt got=%b want=1", stall); end
        flush = 1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_nostall got=%b want=0", stall); end
        flush = 0; rst = 1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_force got=%b want=0", stall); end
        tick();
        rst = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_clear got=%b want=0", stall); end
        total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", stall_count); end
        tick();
    endtask

    initial begin
        clr();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_multi_cycle();
        test_waw();
        test_priority_zero();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
